// File: rtl/response_sequencer.sv
// Streams a fixed ASCII reply over a valid/ready byte interface on each trigger pulse.
// Optional CR/LF terminator is enabled with `define RESPONSE_SEQUENCER_CRLF_EN.
module response_sequencer #(
  parameter int unsigned               MSG_LEN    = 4,
  parameter logic [8*MSG_LEN-1:0]      MSG        = 32'h504F4C4F,
  parameter int unsigned               GAP_CYCLES = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trigger,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       dropped
);

`ifdef RESPONSE_SEQUENCER_CRLF_EN
  localparam int unsigned TOTAL = MSG_LEN + 2;
`else
  localparam int unsigned TOTAL = MSG_LEN;
`endif

  localparam logic [4:0]  LAST       = 5'(TOTAL - 1);
  localparam logic [15:0] GAP_RELOAD = (GAP_CYCLES == 0) ? '0 : 16'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t      state, state_nxt;
  logic [4:0]  idx, idx_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic        pending, pending_nxt;
  logic [7:0]  data_nxt;
  logic        valid_nxt, busy_nxt, done_nxt, dropped_nxt;

  logic handshake, last;
  assign handshake = tx_valid && tx_ready;
  assign last      = (idx == LAST);

  function automatic logic [7:0] byte_at(input logic [4:0] i);
    logic [7:0] b;
    b = '0;
    for (int unsigned k = 0; k < MSG_LEN; k++)
      if (i == 5'(k)) b = MSG[8*(MSG_LEN-1-k) +: 8];
`ifdef RESPONSE_SEQUENCER_CRLF_EN
    if (i == 5'(MSG_LEN))     b = 8'h0D;
    if (i == 5'(MSG_LEN + 1)) b = 8'h0A;
`endif
    return b;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      cnt      <= '0;
      pending  <= 1'b0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      dropped  <= 1'b0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      cnt      <= cnt_nxt;
      pending  <= pending_nxt;
      tx_data  <= data_nxt;
      tx_valid <= valid_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      dropped  <= dropped_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (trigger || pending) state_nxt = SEND;
      SEND: if (handshake) begin
        if (last)                 state_nxt = IDLE;
        else if (GAP_CYCLES != 0) state_nxt = GAP;
      end
      GAP:  if (cnt == '0) state_nxt = SEND;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    idx_nxt     = idx;
    cnt_nxt     = cnt;
    pending_nxt = pending;
    data_nxt    = tx_data;
    valid_nxt   = tx_valid;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    dropped_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (trigger || pending) begin
          busy_nxt    = 1'b1;
          idx_nxt     = '0;
          data_nxt    = byte_at(5'd0);
          valid_nxt   = 1'b1;
          // A trigger arriving while a queued request starts takes the freed slot
          pending_nxt = trigger && pending;
        end
      end
      SEND: begin
        if (trigger) begin
          if (pending) dropped_nxt = 1'b1;
          else         pending_nxt = 1'b1;
        end
        if (handshake) begin
          if (last) begin
            valid_nxt = 1'b0;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
          end else if (GAP_CYCLES == 0) begin
            idx_nxt  = idx + 5'd1;
            data_nxt = byte_at(idx + 5'd1);
          end else begin
            valid_nxt = 1'b0;
            cnt_nxt   = GAP_RELOAD;
          end
        end
      end
      GAP: begin
        if (trigger) begin
          if (pending) dropped_nxt = 1'b1;
          else         pending_nxt = 1'b1;
        end
        if (cnt == '0) begin
          idx_nxt   = idx + 5'd1;
          data_nxt  = byte_at(idx + 5'd1);
          valid_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt - 16'd1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_response_sequencer.sv
// Directed bench for response_sequencer: back-to-back, backpressure, gap, queue/drop and reset abort.
module tb_response_sequencer;

`ifdef RESPONSE_SEQUENCER_CRLF_EN
  localparam int N = 6;
`else
  localparam int N = 4;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       trigger, tx_ready;
  logic [7:0] tx_data;
  logic       tx_valid, busy, done, dropped;
  logic       trigger_g, tx_ready_g;
  logic [7:0] tx_data_g;
  logic       tx_valid_g, busy_g, done_g, dropped_g;

  logic [7:0] exp_b [6];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  response_sequencer #(.MSG_LEN(4), .MSG(32'h504F4C4F), .GAP_CYCLES(0)) dut (
    .clk(clk), .rst(rst), .trigger(trigger), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .done(done), .dropped(dropped)
  );

  response_sequencer #(.MSG_LEN(4), .MSG(32'h504F4C4F), .GAP_CYCLES(3)) dut_gap (
    .clk(clk), .rst(rst), .trigger(trigger_g), .tx_data(tx_data_g), .tx_valid(tx_valid_g),
    .tx_ready(tx_ready_g), .busy(busy_g), .done(done_g), .dropped(dropped_g)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    logic [3:0] pat;
    exp_b[0] = 8'h50; exp_b[1] = 8'h4F; exp_b[2] = 8'h4C; exp_b[3] = 8'h4F;
    exp_b[4] = 8'h0D; exp_b[5] = 8'h0A;
    pat = 4'b1001;

    rst = 1'b1; trigger = 1'b0; tx_ready = 1'b1; trigger_g = 1'b0; tx_ready_g = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rst_valid", tx_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dropped", dropped, 0);
    check("rst_data", tx_data, 8'h00);
    check("rst_valid_g", tx_valid_g, 0);

    // back-to-back reply
    tick();
    check("idle_valid", tx_valid, 0);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    for (int i = 0; i < N; i++) begin
      check($sformatf("b2b_valid%0d", i), tx_valid, 1);
      check($sformatf("b2b_data%0d", i), tx_data, exp_b[i]);
      check($sformatf("b2b_busy%0d", i), busy, 1);
      check($sformatf("b2b_done%0d", i), done, 0);
      tick();
    end
    check("b2b_end_valid", tx_valid, 0);
    check("b2b_end_busy", busy, 0);
    check("b2b_end_done", done, 1);
    tick();
    check("b2b_done_pulse", done, 0);

    // backpressure, ready pattern 1,0,0,1
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    k = 0;
    for (int c = 0; c < 100 && k < N; c++) begin
      check($sformatf("bp_valid_c%0d", c), tx_valid, 1);
      check($sformatf("bp_data_c%0d", c), tx_data, exp_b[k]);
      tx_ready = pat[c % 4];
      tick();
      if (tx_ready) k++;
    end
    check("bp_count", k, N);
    check("bp_done", done, 1);
    check("bp_end_valid", tx_valid, 0);
    tx_ready = 1'b1;
    tick();

    // inter-byte gap of 3 cycles
    trigger_g = 1'b1;
    tick();
    trigger_g = 1'b0;
    for (int i = 0; i < N; i++) begin
      check($sformatf("gap_valid%0d", i), tx_valid_g, 1);
      check($sformatf("gap_data%0d", i), tx_data_g, exp_b[i]);
      tick();
      if (i < N - 1)
        for (int g = 0; g < 3; g++) begin
          check($sformatf("gap_low%0d_%0d", i, g), tx_valid_g, 0);
          check($sformatf("gap_busy%0d_%0d", i, g), busy_g, 1);
          tick();
        end
    end
    check("gap_done", done_g, 1);
    check("gap_end_valid", tx_valid_g, 0);
    tick();

    // queue one request, drop the next
    trigger = 1'b1;
    tick();
    for (int i = 0; i < N; i++) begin
      check($sformatf("q1_data%0d", i), tx_data, exp_b[i]);
      check($sformatf("q1_valid%0d", i), tx_valid, 1);
      trigger = (i == 0 || i == 1);
      tick();
      check($sformatf("q1_dropped%0d", i), dropped, (i == 1) ? 1 : 0);
    end
    trigger = 1'b0;
    check("q1_done", done, 1);
    check("q1_gap_busy", busy, 0);
    tick();
    for (int i = 0; i < N; i++) begin
      check($sformatf("q2_data%0d", i), tx_data, exp_b[i]);
      check($sformatf("q2_busy%0d", i), busy, 1);
      tick();
    end
    check("q2_done", done, 1);
    tick();
    check("q3_none_valid", tx_valid, 0);
    check("q3_none_busy", busy, 0);

    // trigger coincident with final handshake is queued, not dropped
    trigger = 1'b1;
    tick();
    for (int i = 0; i < N; i++) begin
      trigger = (i == N - 1);
      tick();
    end
    trigger = 1'b0;
    check("sim_done", done, 1);
    check("sim_dropped", dropped, 0);
    check("sim_busy", busy, 0);
    tick();
    check("sim_restart_valid", tx_valid, 1);
    check("sim_restart_data", tx_data, 8'h50);
    check("sim_restart_done", done, 0);

    // reset mid-reply after two bytes accepted, with a pending request
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    tick();
    check("abort_pre_data", tx_data, exp_b[2]);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_valid", tx_valid, 0);
    check("abort_busy", busy, 0);
    tick(); tick();
    check("abort_no_pending", tx_valid, 0);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    check("restart_valid", tx_valid, 1);
    check("restart_data", tx_data, 8'h50);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/response_sequencer.md
Name: response_sequencer

Overview:
- Sits between the "MARCO" match detector and the byte-wide UART transmitter.
- On each one-cycle trigger pulse it streams a fixed ASCII reply ("POLO" by default) one byte at a time over a valid/ready handshake.
- It tracks one pending request that arrives while a reply is in flight.
- It reports busy, completion and dropped-request status for the LED driver and the debug pins.

Parameters:
- MSG_LEN, 4, number of message bytes (1..16).
- MSG, "POLO" (32'h504F4C4F), packed message of 8*MSG_LEN bits; the first byte sent is MSG[8*MSG_LEN-1 -: 8].
- GAP_CYCLES, 0, idle clocks inserted between an accepted byte and the next tx_valid (0..65535).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- trigger  in  1  one-cycle request pulse from the match detector
- tx_data  out  8  byte presented to the UART TX
- tx_valid  out  1  tx_data is valid
- tx_ready  in  1  UART TX accepts the byte; a transfer occurs on a rising edge where tx_valid&&tx_ready
- busy  out  1  a reply is in progress
- done  out  1  one-cycle pulse after the final byte is accepted
- dropped  out  1  one-cycle pulse when a trigger is discarded

Behaviour:
- Single clock domain: clk. Reset is synchronous, active-high on rst, and has priority over all inputs.
- Reset values: tx_data=8'h00, tx_valid=0, busy=0, done=0, dropped=0, byte index=0, gap counter=0, pending=0, state=IDLE.
- All outputs are registered. There is no combinational path from any input to any output.
- States: IDLE, SEND, GAP.
- IDLE, trigger=1 (or pending=1):
  - On the next edge: state=SEND, busy=1, index=0, tx_data=byte0, tx_valid=1, pending cleared.
  - Latency from trigger to tx_valid is 1 cycle.
- SEND:
  - tx_valid and tx_data are held stable until a handshake occurs. tx_ready may stall indefinitely.
  - On handshake, if index==MSG_LEN-1: tx_valid=0, busy=0, done=1 for one cycle, state=IDLE.
  - On handshake, otherwise:
    - GAP_CYCLES==0: index+1, tx_data=next byte, tx_valid stays 1 (back-to-back, no bubble).
    - GAP_CYCLES>0: tx_valid=0, counter=GAP_CYCLES-1, state=GAP.
- GAP:
  - Counter decrements each cycle.
  - When the counter is 0: index+1, tx_data=next byte, tx_valid=1, state=SEND.
  - tx_valid is low for exactly GAP_CYCLES cycles.
- Requests while busy:
  - A trigger while busy=1 sets pending=1 (one-deep queue).
  - A trigger while pending is already 1 is discarded and dropped pulses for 1 cycle.
- Simultaneous events:
  - A trigger on the same edge as the final handshake is captured as pending. No drop, unless pending was already set.
  - After done, if pending=1, IDLE starts a new reply on the following edge: busy low for exactly 1 cycle, done and busy=0 visible together.
- tx_ready is ignored while tx_valid=0.
- Index never exceeds MSG_LEN-1. No wrap-around within a reply.
- Reset mid-reply aborts immediately: tx_valid drops on the reset edge, the partial message is not resumed, and pending is cleared.
- tx_data holds the last byte after completion. Its value is don't-care when tx_valid=0, but it must not glitch while tx_valid=1.

Optional Feature:
- Macro: RESPONSE_SEQUENCER_CRLF_EN.
- Defined: two bytes, 8'h0D then 8'h0A, are appended after the MSG bytes.
  - They obey the same handshake and GAP rules.
  - done fires after the 8'h0A handshake. Total bytes = MSG_LEN+2.
- Undefined: exactly MSG_LEN bytes are sent, with no terminator logic synthesised.

Test Plan:
- Reset, then trigger with tx_ready=1, GAP_CYCLES=0 -> tx_valid rises 1 cycle later; bytes 50,4F,4C,4F on 4 consecutive cycles; done pulses on the next cycle; busy high for 4 cycles.
- tx_ready toggles 1,0,0,1,... (backpressure) -> each byte held stable while stalled; no byte lost or repeated; sequence is still 50,4F,4C,4F.
- GAP_CYCLES=3 -> exactly 3 cycles with tx_valid=0 between each accepted byte and the next byte; 4 bytes total.
- Trigger, then 2 more triggers mid-reply -> second trigger is queued and the third pulses dropped; after done, a second "POLO" starts with busy low for 1 cycle; exactly 8 bytes in total.
- Assert rst after the second byte is accepted -> tx_valid=0 and busy=0 on the next edge; the next trigger restarts from 8'h50.
- With RESPONSE_SEQUENCER_CRLF_EN defined -> 50,4F,4C,4F,0D,0A, then done; without it -> done after 4F.
